sample_decoder: RTL and testbench
=================================

Name: sample_decoder

Overview:
- Receive-side counterpart of the `sample` 4-to-5-bit encoder.
- Code word is 5 bits: {p, d[3:0]}, where p = ^d (even parity over the data).
- Accepts code words on a valid/ready input, checks parity, strips the parity bit and presents 4-bit data with an error flag through a small output FIFO.
- Keeps a saturating count of parity errors. Sits between the channel that carries encoder output and the 4-bit consumer.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, 2 or larger.
- CNT_W, 8, width of the parity-error counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  code word on in_code is valid
- in_code  input  5  {p, d[3:0]}
- in_ready  output  1  decoder can accept a word this cycle
- out_valid  output  1  FIFO head is valid
- out_data  output  4  decoded d[3:0] of the FIFO head
- out_err  output  1  parity mismatch flag of the FIFO head
- out_ready  input  1  consumer takes the head this cycle
- cnt_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating parity-error count
- err_seen  output  1  sticky: high once any error has been accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; out_valid=0, out_data=0, out_err=0.
  - err_cnt=0, err_seen=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer drops all buffered words with no output.
- Accept rule: accept = in_valid & in_ready.
  - in_ready = !full. It is registered-state based and never depends combinationally on out_ready, so there is no bypass when full.
- Decode on accept:
  - data = in_code[3:0]
  - err = in_code[4] ^ (^in_code[3:0])
  - {err, data} is pushed into the FIFO.
- Latency: a word accepted at edge N is visible with out_valid=1 at edge N+1. There is no combinational in-to-out path.
- Pop rule: pop = out_valid & out_ready. out_data and out_err are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - When not full and not empty, both happen and occupancy is unchanged.
  - When empty, only a push is possible.
  - When full, in_ready=0, so only a pop is possible. in_ready rises the cycle after the pop.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Full/empty are derived from an occupancy count of width log2(DEPTH)+1.
- err_cnt:
  - Increments by 1 on each accepted word with err=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - If cnt_clr and an erroring accept occur in the same cycle, the result is err_cnt=1.
  - If cnt_clr occurs alone, the result is 0.
- err_seen: set on the first erroring accept. It is cleared only by rst, not by cnt_clr.
- Words presented while in_ready=0 are ignored: no decode, no count.
- State: the FIFO occupancy states EMPTY, PARTIAL and FULL, derived from the count. There is no other FSM.

Decomposition:
- Package sample_pkg:
  - CODE_W=5, DATA_W=4.
  - Function parity_of(d) returning ^d, shared with the encoder.
  - Packed type dec_word_t = {err, data[3:0]}.
- One sub-module, sample_fifo:
  - Parameterised WIDTH/DEPTH synchronous FIFO.
  - Ports: push, pop, wdata, rdata, full, empty.
  - sample_decoder instantiates it with WIDTH=5.

Test Plan:
- Good words: with out_ready=1, send 5'b0_0000, then 5'b1_0111, then 5'b0_1111.
  - Outputs one cycle later: data 0000/0111/1111, out_err=0 for all three.
  - err_cnt=0, err_seen=0.
- Bad word: send 5'b0_0111.
  - out_data=0111, out_err=1.
  - err_cnt=1 and err_seen=1 at the edge after the accept.
- Backpressure: hold out_ready=0 and stream 4 words.
  - The first 2 are accepted and in_ready=0 after the second.
  - The head stays at the first word.
  - Release out_ready for 1 cycle: the first word pops and in_ready=1 on the next cycle.
  - Order is preserved for all words.
- Saturation: send 300 bad words, e.g. 5'b1_0000, with out_ready=1.
  - err_cnt=255 and it stays at 255.
  - cnt_clr together with a bad accept gives err_cnt=1.
  - cnt_clr alone gives 0; err_seen remains 1.
- Reset mid-operation: with the FIFO full and err_cnt=5, assert rst for 1 cycle.
  - Next cycle: out_valid=0, err_cnt=0, err_seen=0, in_ready=1.
  - No stale words appear afterward.
- Exhaustive: all 32 code words, back-to-back.
  - out_err=1 exactly for the 16 words with odd overall parity.
  - out_data equals in_code[3:0] for every word.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared types and helpers for the 4b/5b parity code (encoder and decoder side).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sample_pkg;

    localparam int CODE_W = 5;
    localparam int DATA_W = 4;

    // Decoded word as stored in the output FIFO: parity error flag over data.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } dec_word_t;

    // FIFO occupancy, derived purely from the occupancy count.
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_t;

    // Even parity over the data nibble; the encoder sends this as the top bit.
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO, WIDTH bits by DEPTH entries (DEPTH a power of two, >= 2).
// Latency: a word pushed at edge N is at the head (empty=0) after edge N.
// Backpressure: push ignored while full, pop ignored while empty; no full-bypass.
module sample_fifo
    import sample_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    occ_state_t       occ;
    logic             do_push;
    logic             do_pop;

    // Occupancy state decoded from the count register.
    always_comb begin
        occ = PARTIAL;
        if (count == '0) begin
            occ = EMPTY;
        end else if (count == DEPTH_C) begin
            occ = FULL;
        end
    end

    assign full    = (occ == FULL);
    assign empty   = (occ == EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is forced to zero when empty so stale storage never shows.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + OCC_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/sample_decoder.sv
// Checks and strips the parity bit of 5-bit code words; keeps a saturating error count.
// Latency: word accepted at edge N appears with out_valid=1 after edge N (one cycle).
// Backpressure: in_ready = !full from registered state only; no bypass when full.
module sample_decoder
    import sample_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_seen
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dec_word_t push_word;
    dec_word_t head_word;
    logic      fifo_full;
    logic      fifo_empty;
    logic      accept;
    logic      pop;
    logic      acc_err;

    assign in_ready  = ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // Decode: data passes through, error is received parity vs recomputed parity.
    always_comb begin
        push_word.data = in_code[DATA_W-1:0];
        push_word.err  = in_code[CODE_W-1] ^ parity_of(in_code[DATA_W-1:0]);
    end

    assign acc_err = accept & push_word.err;

    sample_fifo #(
        .WIDTH ($bits(dec_word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (push_word),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data = head_word.data;
    assign out_err  = head_word.err;

    // Saturating error counter; a clear coinciding with an erroring accept leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= acc_err ? CNT_W'(1) : '0;
        end else if (acc_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // Sticky error indication; only reset clears it, cnt_clr does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_seen <= 1'b0;
        end else if (acc_err) begin
            err_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_decoder.sv
// Scoreboard bench for sample_decoder: stimulus pushes expected words, monitor pops on output handshakes.
// Latency: checks one-cycle accept-to-output visibility and in_ready recovery after a pop.
// Backpressure: exercised by holding out_ready low with a full FIFO.
module tb_sample_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_err;
    logic       out_ready;
    logic       cnt_clr;
    logic [7:0] err_cnt;
    logic       err_seen;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;

    logic [4:0] sb [$];

    always #5 clk = ~clk;

    sample_decoder #(
        .DEPTH (2),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .err_cnt   (err_cnt),
        .err_seen  (err_seen)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got err=%0b data=%0h expected nothing", out_err, out_data);
            end else begin
                e = sb.pop_front();
                check("out_word", {27'd0, out_err, out_data}, {27'd0, e});
            end
        end
    end

    // Present one code word, wait (bounded) for acceptance, record expectation.
    // Entered and left just after a rising edge.
    task automatic send(input logic [4:0] code, input logic [3:0] exp_data, input logic exp_err);
        int waited = 0;
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
        if (in_ready) begin
            sb.push_back({exp_err, exp_data});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 5'd0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {28'd0, out_data}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_err_seen", {31'd0, err_seen}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Good words, one-cycle latency
        out_ready = 1'b1;
        send(5'b0_0000, 4'h0, 1'b0);
        send(5'b1_0111, 4'h7, 1'b0);
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_data", {28'd0, out_data}, 32'd7);
        send(5'b0_1111, 4'hF, 1'b0);
        idle(2);
        check("good_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("good_err_seen", {31'd0, err_seen}, 32'd0);

        // Bad word
        send(5'b0_0111, 4'h7, 1'b1);
        check("bad_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("bad_err_seen", {31'd0, err_seen}, 32'd1);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        send(5'b1_0001, 4'h1, 1'b0);
        send(5'b1_0010, 4'h2, 1'b0);
        fork
            send(5'b0_0011, 4'h3, 1'b0);
            begin
                @(negedge clk);
                check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_head0", {28'd0, out_data}, 32'd1);
                @(negedge clk);
                check("bp_head1", {28'd0, out_data}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
            end
        join
        out_ready = 1'b1;
        send(5'b1_0100, 4'h4, 1'b0);
        idle(4);
        check("bp_err_cnt", {24'd0, err_cnt}, 32'd1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            send(5'b1_0000, 4'h0, 1'b1);
        end
        check("sat_255", {24'd0, err_cnt}, 32'd255);
        send(5'b1_0000, 4'h0, 1'b1);
        send(5'b1_0000, 4'h0, 1'b1);
        check("sat_hold", {24'd0, err_cnt}, 32'd255);
        cnt_clr = 1'b1;
        send(5'b1_0000, 4'h0, 1'b1);
        cnt_clr = 1'b0;
        check("clr_with_err", {24'd0, err_cnt}, 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_alone", {24'd0, err_cnt}, 32'd0);
        check("clr_keeps_seen", {31'd0, err_seen}, 32'd1);
        idle(2);

        // Reset mid-operation with a full FIFO
        for (int i = 0; i < 5; i++) begin
            send(5'b1_0000, 4'h0, 1'b1);
        end
        idle(2);
        out_ready = 1'b0;
        send(5'b0_0000, 4'h0, 1'b0);
        send(5'b0_0101, 4'h5, 1'b0);
        in_valid = 1'b1;
        in_code  = 5'b1_0000;
        idle(2);
        in_valid = 1'b0;
        check("full_ignored_cnt", {24'd0, err_cnt}, 32'd5);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_err_seen", {31'd0, err_seen}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        n_pop = 0;
        out_ready = 1'b1;
        idle(5);
        check("no_stale_words", n_pop, 32'd0);

        // Exhaustive: err flags exactly the words with odd overall parity
        for (int i = 0; i < 32; i++) begin
            logic [4:0] c;
            c = 5'(i);
            send(c, c[3:0], logic'($countones(c) % 2));
        end
        idle(3);
        check("exh_err_cnt", {24'd0, err_cnt}, 32'd16);

        // Drain
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
